// File: rtl/ctrl_cmd_serializer_pkg.sv
// Shared command codes, payload lengths and state type for the
// control byte serializer.
package ctrl_cmd_serializer_pkg;

    localparam logic [7:0] CMD_BEGIN_PROGRAM      = 8'h01;
    localparam logic [7:0] CMD_WRITE_BLOCK_INSTR  = 8'h02;
    localparam logic [7:0] CMD_WRITE_BLOCK_REG_0  = 8'h03;
    localparam logic [7:0] CMD_WRITE_BLOCK_REG_1  = 8'h04;
    localparam logic [7:0] CMD_ALLOC_DELAY        = 8'h05;
    localparam logic [7:0] CMD_END_PROGRAM        = 8'h06;
    localparam logic [7:0] CMD_SET_INPUT_GAIN     = 8'h07;
    localparam logic [7:0] CMD_SET_OUTPUT_GAIN    = 8'h08;
    localparam logic [7:0] CMD_UPDATE_BLOCK_REG_0 = 8'h09;
    localparam logic [7:0] CMD_UPDATE_BLOCK_REG_1 = 8'h0A;
    localparam logic [7:0] CMD_COMMIT_REG_UPDATES = 8'h0B;

    localparam int CMD_MAX_PAYLOAD   = 6;
    localparam int CMD_LEN_INSTR     = 4;
    localparam int CMD_LEN_DELAY     = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

endpackage

// File: rtl/ctrl_cmd_serializer_len.sv
// Opcode to payload length lookup; opcode-only commands and unknown
// codes carry no payload.
module ctrl_cmd_len
    import ctrl_cmd_serializer_pkg::*;
#(
    parameter int BLOCK_BYTES = 1,
    parameter int DATA_BYTES  = 2
) (
    input  logic [7:0] opcode,
    output logic [2:0] len
);

    always_comb begin
        len = 3'd0;
        case (opcode)
            CMD_WRITE_BLOCK_INSTR:
                len = 3'(BLOCK_BYTES + CMD_LEN_INSTR);
            CMD_WRITE_BLOCK_REG_0, CMD_WRITE_BLOCK_REG_1,
            CMD_UPDATE_BLOCK_REG_0, CMD_UPDATE_BLOCK_REG_1:
                len = 3'(BLOCK_BYTES + DATA_BYTES);
            CMD_ALLOC_DELAY:
                len = 3'(CMD_LEN_DELAY);
            CMD_SET_INPUT_GAIN, CMD_SET_OUTPUT_GAIN:
                len = 3'(DATA_BYTES);
            default:
                len = 3'd0;
        endcase
    end

endmodule

// File: rtl/ctrl_cmd_serializer.sv
// Serializes one structured command into control_unit's byte protocol,
// paced by the receiver's next pulse, with a stall timeout.
module ctrl_cmd_serializer
    import ctrl_cmd_serializer_pkg::*;
#(
    parameter int N_BLOCKS     = 256,
    parameter int DATA_WIDTH   = 16,
    parameter int NEXT_TIMEOUT = 1024
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [7:0]                                cmd_opcode,
    input  logic [((N_BLOCKS > 256) ? 16 : 8)-1:0]    cmd_block,
    input  logic [31:0]                               cmd_instr,
    input  logic [DATA_WIDTH-1:0]                     cmd_data,
    input  logic [23:0]                               cmd_delay_size,
    input  logic [23:0]                               cmd_init_delay,
    output logic [7:0]                                out_byte,
    output logic                                      out_valid,
    input  logic                                      next,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      timeout_err,
    output logic [15:0]                               bytes_sent
);

    localparam int BLOCK_BYTES = (N_BLOCKS > 256) ? 2 : 1;
    localparam int DATA_BYTES  = (DATA_WIDTH == 24) ? 3 : 2;
    localparam int BW          = 8 * BLOCK_BYTES;
    localparam int TW          = $clog2(NEXT_TIMEOUT);

    state_t        state;
    logic [55:0]   sr;
    logic [2:0]    rem;
    logic [2:0]    len;
    logic [TW-1:0] cnt;
    logic [47:0]   payload;

    ctrl_cmd_len #(
        .BLOCK_BYTES(BLOCK_BYTES),
        .DATA_BYTES (DATA_BYTES)
    ) u_len (
        .opcode(cmd_opcode),
        .len   (len)
    );

    // Payload is left-aligned so the shift register always emits MSB first.
    always_comb begin
        payload = '0;
        case (cmd_opcode)
            CMD_WRITE_BLOCK_INSTR:
                payload = 48'({cmd_block, cmd_instr}) << (48 - BW - 32);
            CMD_WRITE_BLOCK_REG_0, CMD_WRITE_BLOCK_REG_1,
            CMD_UPDATE_BLOCK_REG_0, CMD_UPDATE_BLOCK_REG_1:
                payload = 48'({cmd_block, cmd_data}) << (48 - BW - DATA_WIDTH);
            CMD_ALLOC_DELAY:
                payload = {cmd_delay_size, cmd_init_delay};
            CMD_SET_INPUT_GAIN, CMD_SET_OUTPUT_GAIN:
                payload = 48'(cmd_data) << (48 - DATA_WIDTH);
            default:
                payload = '0;
        endcase
    end

    assign out_byte = sr[55:48];
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sr          <= '0;
            rem         <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            cmd_ready   <= 1'b1;
            bytes_sent  <= '0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        sr        <= {cmd_opcode, payload};
                        rem       <= len;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= S_SEND;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (next) begin
                        out_valid  <= 1'b0;
                        sr         <= {sr[47:0], 8'h00};
                        bytes_sent <= bytes_sent + 16'd1;
                        if (rem == 3'd0) begin
                            done  <= 1'b1;
                            sr    <= '0;
                            state <= S_IDLE;
                        end else begin
                            rem   <= rem - 3'd1;
                            state <= S_GAP;
                        end
                    end else if (cnt == TW'(NEXT_TIMEOUT - 1)) begin
                        out_valid   <= 1'b0;
                        timeout_err <= 1'b1;
                        sr          <= '0;
                        rem         <= '0;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    state     <= S_SEND;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_cmd_serializer.sv
// Bench for ctrl_cmd_serializer: directed and random commands checked
// against a byte-list model of the control protocol.
module tb_ctrl_cmd_serializer;
    import ctrl_cmd_serializer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [7:0]  cmd_block;
    logic [31:0] cmd_instr;
    logic [15:0] cmd_data;
    logic [23:0] cmd_delay_size;
    logic [23:0] cmd_init_delay;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        next;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] bytes_sent;

    ctrl_cmd_serializer #(
        .N_BLOCKS    (256),
        .DATA_WIDTH  (16),
        .NEXT_TIMEOUT(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_block     (cmd_block),
        .cmd_instr     (cmd_instr),
        .cmd_data      (cmd_data),
        .cmd_delay_size(cmd_delay_size),
        .cmd_init_delay(cmd_init_delay),
        .out_byte      (out_byte),
        .out_valid     (out_valid),
        .next          (next),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err),
        .bytes_sent    (bytes_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int n_done, n_tout, vcyc, timing_bad, done_cyc, ack_cyc, first_cyc;
    int total = 0;

    logic [7:0] codes[14] = '{CMD_BEGIN_PROGRAM, CMD_WRITE_BLOCK_INSTR,
        CMD_WRITE_BLOCK_REG_0, CMD_WRITE_BLOCK_REG_1, CMD_ALLOC_DELAY,
        CMD_END_PROGRAM, CMD_SET_INPUT_GAIN, CMD_SET_OUTPUT_GAIN,
        CMD_UPDATE_BLOCK_REG_0, CMD_UPDATE_BLOCK_REG_1,
        CMD_COMMIT_REG_UPDATES, 8'h00, 8'hFF, 8'h3C};

    // Expected wire bytes: opcode, then fields MSB first.
    task automatic model(input logic [7:0] op, input logic [7:0] blk,
                         input logic [31:0] instr, input logic [15:0] data,
                         input logic [23:0] size, input logic [23:0] init);
        exp_q.delete();
        exp_q.push_back(op);
        if (op == CMD_WRITE_BLOCK_INSTR) begin
            exp_q.push_back(blk);
            for (int s = 24; s >= 0; s -= 8) exp_q.push_back(8'(instr >> s));
        end else if (op == CMD_WRITE_BLOCK_REG_0 || op == CMD_WRITE_BLOCK_REG_1 ||
                     op == CMD_UPDATE_BLOCK_REG_0 || op == CMD_UPDATE_BLOCK_REG_1) begin
            exp_q.push_back(blk);
            exp_q.push_back(8'(data >> 8));
            exp_q.push_back(8'(data));
        end else if (op == CMD_ALLOC_DELAY) begin
            for (int s = 16; s >= 0; s -= 8) exp_q.push_back(8'(size >> s));
            for (int s = 16; s >= 0; s -= 8) exp_q.push_back(8'(init >> s));
        end else if (op == CMD_SET_INPUT_GAIN || op == CMD_SET_OUTPUT_GAIN) begin
            exp_q.push_back(8'(data >> 8));
            exp_q.push_back(8'(data));
        end
    endtask

    function automatic bit q_eq();
        if (cap_q.size() != exp_q.size()) return 1'b0;
        foreach (cap_q[i]) if (cap_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Issues one command and plays receiver; returns at done, timeout,
    // or with reset raised when byte rst_byte first appears.
    task automatic xfer(input logic [7:0] op, input logic [7:0] blk,
                        input logic [31:0] instr, input logic [15:0] data,
                        input logic [23:0] size, input logic [23:0] init,
                        input int lat_lo, input int lat_hi, input bit never_ack,
                        input int rst_byte, input bit spam);
        int cyc, wait_c, lat, gap_len;
        bit prev_v, finished;
        logic [7:0] held;
        cap_q.delete();
        n_done = 0; n_tout = 0; vcyc = 0; timing_bad = 0;
        done_cyc = -1; ack_cyc = -2; first_cyc = -1;
        cyc = 0; wait_c = 0; lat = 0; gap_len = 0; prev_v = 0; finished = 0;
        held = '0;
        for (int g = 0; g < 10 && !cmd_ready; g++) begin
            @(posedge clk); #1;
        end
        cmd_opcode = op; cmd_block = blk; cmd_instr = instr; cmd_data = data;
        cmd_delay_size = size; cmd_init_delay = init;
        cmd_valid = 1'b1;
        while (cyc < 300 && !finished) begin
            @(posedge clk); #1;
            cyc++;
            next = 1'b0;
            if (cyc == 1) begin
                cmd_valid = spam;
                cmd_opcode = CMD_ALLOC_DELAY;
                cmd_delay_size = 24'hA5A5A5;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (timeout_err) n_tout++;
            if (out_valid) begin
                if (!prev_v) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    if (cap_q.size() > 0 && gap_len != 1) timing_bad++;
                    if (rst_byte != 0 && cap_q.size() == rst_byte - 1) begin
                        reset = 1'b1;
                        finished = 1;
                    end
                    wait_c = 0;
                    lat = $urandom_range(lat_hi, lat_lo);
                    held = out_byte;
                end else if (out_byte !== held) begin
                    timing_bad++;
                end
                gap_len = 0;
                vcyc++;
                if (!finished && !never_ack && wait_c == lat) begin
                    next = 1'b1;
                    cap_q.push_back(out_byte);
                    ack_cyc = cyc;
                end
                wait_c++;
            end else begin
                gap_len++;
            end
            prev_v = out_valid;
            if (n_done > 0 || n_tout > 0) finished = 1;
        end
        cmd_valid = 1'b0;
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_bound op=%02h: no done/timeout within 300 cycles", op);
        end
        total += cap_q.size();
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; next = 1'b0;
        cmd_opcode = '0; cmd_block = '0; cmd_instr = '0; cmd_data = '0;
        cmd_delay_size = '0; cmd_init_delay = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_byte, done, timeout_err, bytes_sent, busy} !== 28'h0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b byte=%02h done=%b terr=%b sent=%0d busy=%b, required all 0",
                     out_valid, out_byte, done, timeout_err, bytes_sent, busy);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b required 1", cmd_ready);
        end
        total = 0;
    endtask

    task automatic test_write_instr();
        model(CMD_WRITE_BLOCK_INSTR, 8'h05, 32'hDEADBEEF, 16'h0, 24'h0, 24'h0);
        xfer(CMD_WRITE_BLOCK_INSTR, 8'h05, 32'hDEADBEEF, 16'h0, 24'h0, 24'h0,
             1, 1, 0, 0, 0);
        n_cmp++;
        if (!q_eq()) begin
            n_bad++;
            $display("FAIL instr_bytes: got %0d bytes, required %0d (first got %02h)",
                     cap_q.size(), exp_q.size(), cap_q.size() ? cap_q[0] : 8'h00);
        end
        n_cmp++;
        if (n_done !== 1 || done_cyc !== ack_cyc + 1) begin
            n_bad++;
            $display("FAIL instr_done: count %0d at cyc %0d, required 1 at %0d",
                     n_done, done_cyc, ack_cyc + 1);
        end
        n_cmp++;
        if (bytes_sent !== 16'd6) begin
            n_bad++;
            $display("FAIL instr_count: got %0d required 6", bytes_sent);
        end
        n_cmp++;
        if (first_cyc !== 1 || timing_bad !== 0) begin
            n_bad++;
            $display("FAIL instr_timing: first valid cyc %0d (required 1), violations %0d (required 0)",
                     first_cyc, timing_bad);
        end
    endtask

    task automatic test_alloc_delay();
        model(CMD_ALLOC_DELAY, 8'h0, 32'h0, 16'h0, 24'h012345, 24'h000010);
        xfer(CMD_ALLOC_DELAY, 8'h0, 32'h0, 16'h0, 24'h012345, 24'h000010,
             1, 9, 0, 0, 0);
        n_cmp++;
        if (!q_eq()) begin
            n_bad++;
            $display("FAIL alloc_bytes: got %0d bytes, required %0d", cap_q.size(), exp_q.size());
        end
        n_cmp++;
        if (timing_bad !== 0 || n_done !== 1 || bytes_sent !== 16'(total)) begin
            n_bad++;
            $display("FAIL alloc_hold: violations %0d done %0d sent %0d, required 0/1/%0d",
                     timing_bad, n_done, bytes_sent, total);
        end
    endtask

    task automatic test_end_program();
        model(CMD_END_PROGRAM, 8'h0, 32'h0, 16'h0, 24'h0, 24'h0);
        xfer(CMD_END_PROGRAM, 8'h0, 32'h0, 16'h0, 24'h0, 24'h0, 1, 3, 0, 0, 0);
        n_cmp++;
        if (!q_eq() || n_done !== 1 || done_cyc !== ack_cyc + 1) begin
            n_bad++;
            $display("FAIL end_prog: bytes %0d done %0d at %0d, required 1 byte, done at %0d",
                     cap_q.size(), n_done, done_cyc, ack_cyc + 1);
        end
        n_cmp++;
        if (cmd_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL end_ready_lag: ready=%b valid=%b in done cycle, required 0/0",
                     cmd_ready, out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL end_ready: ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_next_ignored();
        next = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        next = 1'b0;
        n_cmp++;
        if (bytes_sent !== 16'(total) || out_valid !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_next: sent %0d valid %b done %b, required %0d/0/0",
                     bytes_sent, out_valid, done, total);
        end
    endtask

    task automatic test_random();
        logic [7:0] op, blk;
        logic [31:0] instr;
        logic [15:0] data;
        logic [23:0] sz, ini;
        for (int k = 0; k < 30; k++) begin
            op = codes[$urandom_range(13, 0)];
            blk = 8'($urandom); instr = $urandom; data = 16'($urandom);
            sz = 24'($urandom); ini = 24'($urandom);
            model(op, blk, instr, data, sz, ini);
            xfer(op, blk, instr, data, sz, ini, 1, 8, 0, 0, 1'($urandom));
            n_cmp++;
            if (!q_eq() || n_done !== 1 || n_tout !== 0 || timing_bad !== 0
                || done_cyc !== ack_cyc + 1) begin
                n_bad++;
                $display("FAIL rand_cmd %0d op=%02h: bytes %0d/%0d done %0d terr %0d viol %0d",
                         k, op, cap_q.size(), exp_q.size(), n_done, n_tout, timing_bad);
            end
            n_cmp++;
            if (bytes_sent !== 16'(total)) begin
                n_bad++;
                $display("FAIL rand_count %0d: got %0d required %0d", k, bytes_sent, total);
            end
        end
    endtask

    task automatic test_timeout();
        int extra;
        xfer(CMD_UPDATE_BLOCK_REG_0, 8'h11, 32'h0, 16'h1234, 24'h0, 24'h0,
             1, 1, 1, 0, 0);
        n_cmp++;
        if (vcyc !== 16 || n_tout !== 1 || n_done !== 0) begin
            n_bad++;
            $display("FAIL timeout: valid cycles %0d terr %0d done %0d, required 16/1/0",
                     vcyc, n_tout, n_done);
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || timeout_err || out_valid) extra++;
        end
        n_cmp++;
        if (extra !== 0 || busy !== 1'b0 || cmd_ready !== 1'b1 || bytes_sent !== 16'(total)) begin
            n_bad++;
            $display("FAIL timeout_idle: stray %0d busy %b ready %b sent %0d, required 0/0/1/%0d",
                     extra, busy, cmd_ready, bytes_sent, total);
        end
    endtask

    task automatic test_reset_mid();
        xfer(CMD_WRITE_BLOCK_INSTR, 8'h22, 32'hCAFEF00D, 16'h0, 24'h0, 24'h0,
             1, 2, 0, 3, 0);
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || bytes_sent !== 16'd0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: valid %b sent %0d done %b ready %b, required 0/0/0/1",
                     out_valid, bytes_sent, done, cmd_ready);
        end
        reset = 1'b0;
        total = 0;
        model(CMD_SET_OUTPUT_GAIN, 8'h0, 32'h0, 16'h7FFF, 24'h0, 24'h0);
        xfer(CMD_SET_OUTPUT_GAIN, 8'h0, 32'h0, 16'h7FFF, 24'h0, 24'h0, 1, 4, 0, 0, 0);
        n_cmp++;
        if (!q_eq() || n_done !== 1 || first_cyc !== 1 || bytes_sent !== 16'd3) begin
            n_bad++;
            $display("FAIL after_reset: bytes %0d done %0d first %0d sent %0d, required 3/1/1/3",
                     cap_q.size(), n_done, first_cyc, bytes_sent);
        end
    endtask

    initial begin
        test_reset();
        test_write_instr();
        test_alloc_delay();
        test_end_program();
        test_next_ignored();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
